// File: rtl/mult_share_arbiter_8.sv
// rtl/mult_share_arbiter_8.sv - round-robin time-shared 8x8 multiplier with tagged result channel
//
// array_multiplier_8: purely combinational 8x8 unsigned shift-and-add array.
//   a, b : 8-bit operands
//   p    : 16-bit product
//
// mult_share_arbiter_8: grants one requester at a time, registers its operands,
// lets the array settle for MUL_LAT cycles, then presents the product tagged
// with the requester index.
//   clk, reset        : clock, synchronous active-high reset
//   req_valid/ready   : per-requester handshake (req_ready is one-hot or zero)
//   req_a, req_b      : packed operands, requester i on bits [8i+7:8i]
//   res_valid/ready   : result handshake
//   res_product       : unsigned product
//   res_id            : requester that owns res_product
//   busy              : high whenever the FSM is not idle

module array_multiplier_8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p + ({8'd0, a} << i);
            end
        end
    end

endmodule

module mult_share_arbiter_8 #(
    parameter  int NUM_REQ = 4,
    parameter  int MUL_LAT = 1,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [15:0]          res_product,
    output logic [ID_W-1:0]      res_id,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [ID_W-1:0]   rr_ptr;
    logic [3:0]        cnt;
    logic [7:0]        op_a;
    logic [7:0]        op_b;
    logic [ID_W-1:0]   op_id;
    logic [15:0]       mul_p;

    logic [ID_W-1:0]   scan_idx [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_any;
    logic [7:0]        sel_a;
    logic [7:0]        sel_b;

    // The array only ever sees the registered operands, so requesters may
    // change their inputs freely once their handshake has completed.
    array_multiplier_8 u_mul (
        .a (op_a),
        .b (op_b),
        .p (mul_p)
    );

    // Scan order starts at rr_ptr and wraps modulo NUM_REQ; the first valid
    // requester in that order wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sel_a     = '0;
        sel_b     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx[k] = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && req_valid[scan_idx[k]]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx[k];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_any && (grant_idx == ID_W'(i))) begin
                grant[i] = 1'b1;
                sel_a    = req_a[8*i +: 8];
                sel_b    = req_b[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    req_ready = grant;
                end
                if (grant_any) begin
                    state_nx = CALC;
                end
            end
            CALC: begin
                if (cnt == 4'd0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cnt         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_id       <= '0;
            res_valid   <= 1'b0;
            res_product <= '0;
            res_id      <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        op_id  <= grant_idx;
                        cnt    <= 4'(MUL_LAT - 1);
                        rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    end
                end
                CALC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        res_product <= mul_p;
                        res_id      <= op_id;
                        res_valid   <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter_8.sv
// tb/tb_mult_share_arbiter_8.sv - directed self-checking bench for mult_share_arbiter_8

module tb_mult_share_arbiter_8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_product;
    logic [1:0]  res_id;
    logic        busy;

    logic        reset4;
    logic [3:0]  req_valid4;
    logic [31:0] req_a4;
    logic [31:0] req_b4;
    logic [3:0]  req_ready4;
    logic        res_valid4;
    logic        res_ready4;
    logic [15:0] res_product4;
    logic [1:0]  res_id4;
    logic        busy4;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_p [4];

    always #5 clk = ~clk;

    mult_share_arbiter_8 #(.NUM_REQ(4), .MUL_LAT(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_product (res_product),
        .res_id      (res_id),
        .busy        (busy)
    );

    mult_share_arbiter_8 #(.NUM_REQ(4), .MUL_LAT(4)) dut4 (
        .clk         (clk),
        .reset       (reset4),
        .req_valid   (req_valid4),
        .req_a       (req_a4),
        .req_b       (req_b4),
        .req_ready   (req_ready4),
        .res_valid   (res_valid4),
        .res_ready   (res_ready4),
        .res_product (res_product4),
        .res_id      (res_id4),
        .busy        (busy4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 4'hF; res_ready = 1'b0;
        req_a = 32'h01020304; req_b = 32'h05060708;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
            end
            checks++;
            if ({res_valid, res_product, res_id, busy} !== 20'd0) begin
                errors++; $display("FAIL reset_outputs: got valid=%b prod=%0d id=%0d busy=%b expected all 0",
                                   res_valid, res_product, res_id, busy);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL reset_first_grant: got %b expected 0001", req_ready);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_single;
        res_ready = 1'b1;
        req_a = 32'd10; req_b = 32'd3; req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001 || busy !== 1'b0) begin
            errors++; $display("FAIL single_grant: got ready=%b busy=%b expected 0001 0", req_ready, busy);
        end
        tick();
        req_valid = 4'b0000;
        checks++;
        if (busy !== 1'b1 || res_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL single_calc: got busy=%b valid=%b ready=%b expected 1 0 0000",
                               busy, res_valid, req_ready);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_product !== 16'd30 || res_id !== 2'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_result: got valid=%b prod=%0d id=%0d busy=%b expected 1 30 0 1",
                               res_valid, res_product, res_id, busy);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_release: got valid=%b busy=%b expected 0 0", res_valid, busy);
        end
    endtask

    task automatic test_all_four;
        int n;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_a = {8'd10, 8'd208, 8'd255, 8'd1};
        req_b = {8'd3, 8'd160, 8'd255, 8'd0};
        exp_p[0] = 16'd0; exp_p[1] = 16'd65025; exp_p[2] = 16'd33280; exp_p[3] = 16'd30;
        res_ready = 1'b1;
        req_valid = 4'hF;
        #1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (req_ready === 4'b0000 && n < 10) begin
                tick(); n++;
            end
            checks++;
            if (req_ready !== (4'b0001 << g)) begin
                errors++; $display("FAIL all4_grant%0d: got %b expected %b", g, req_ready, 4'b0001 << g);
            end
            tick();
            req_valid = req_valid & ~(4'b0001 << g);
            n = 0;
            while (res_valid !== 1'b1 && n < 10) begin
                tick(); n++;
            end
            checks++;
            if (res_product !== exp_p[g]) begin
                errors++; $display("FAIL all4_product%0d: got %0d expected %0d", g, res_product, exp_p[g]);
            end
            checks++;
            if (res_id !== 2'(g)) begin
                errors++; $display("FAIL all4_id%0d: got %0d expected %0d", g, res_id, g);
            end
        end
    endtask

    task automatic test_wrap;
        req_a = {8'd0, 8'd6, 8'd0, 8'd2};
        req_b = {8'd0, 8'd7, 8'd0, 8'd5};
        req_valid = 4'b0101;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL wrap_no_grant_in_done: got %b expected 0000", req_ready);
        end
        tick();
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL wrap_first: got %b expected 0001", req_ready);
        end
        tick();
        req_valid = 4'b0100;
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_product !== 16'd10 || res_id !== 2'd0) begin
            errors++; $display("FAIL wrap_res0: got valid=%b prod=%0d id=%0d expected 1 10 0",
                               res_valid, res_product, res_id);
        end
        tick();
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL wrap_second: got %b expected 0100", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_product !== 16'd42 || res_id !== 2'd2) begin
            errors++; $display("FAIL wrap_res2: got valid=%b prod=%0d id=%0d expected 1 42 2",
                               res_valid, res_product, res_id);
        end
        tick();
    endtask

    task automatic test_backpressure;
        res_ready = 1'b0;
        req_a = {8'd0, 8'd0, 8'd12, 8'd7};
        req_b = {8'd0, 8'd0, 8'd12, 8'd9};
        req_valid = 4'b0011;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL bp_grant0: got %b expected 0001", req_ready);
        end
        tick();
        req_valid = 4'b0010;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (res_valid !== 1'b1 || res_product !== 16'd63 || res_id !== 2'd0
                || req_ready !== 4'b0000 || busy !== 1'b1) begin
                errors++; $display("FAIL bp_hold%0d: got valid=%b prod=%0d id=%0d ready=%b busy=%b expected 1 63 0 0000 1",
                                   c, res_valid, res_product, res_id, req_ready, busy);
            end
            tick();
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_accept_cycle: got %b expected 0000", req_ready);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0 || res_product !== 16'd63 || req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_after_accept: got valid=%b prod=%0d ready=%b expected 0 63 0010",
                               res_valid, res_product, req_ready);
        end
        tick();
        req_valid = 4'b0000;
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_product !== 16'd144 || res_id !== 2'd1) begin
            errors++; $display("FAIL bp_res1: got valid=%b prod=%0d id=%0d expected 1 144 1",
                               res_valid, res_product, res_id);
        end
        tick();
    endtask

    task automatic test_reset_calc;
        int n;
        logic seen;
        res_ready4 = 1'b1;
        req_a4 = {8'd0, 8'd5, 8'd0, 8'd0};
        req_b4 = {8'd0, 8'd5, 8'd0, 8'd0};
        reset4 = 1'b0;
        req_valid4 = 4'b0100;
        #1;
        checks++;
        if (req_ready4 !== 4'b0100) begin
            errors++; $display("FAIL rc_grant2: got %b expected 0100", req_ready4);
        end
        tick();
        req_valid4 = 4'b0000;
        tick();
        tick();
        checks++;
        if (busy4 !== 1'b1 || res_valid4 !== 1'b0) begin
            errors++; $display("FAIL rc_in_calc: got busy=%b valid=%b expected 1 0", busy4, res_valid4);
        end
        reset4 = 1'b1;
        tick();
        checks++;
        if (busy4 !== 1'b0 || res_valid4 !== 1'b0 || res_product4 !== 16'd0) begin
            errors++; $display("FAIL rc_after_reset: got busy=%b valid=%b prod=%0d expected 0 0 0",
                               busy4, res_valid4, res_product4);
        end
        reset4 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (res_valid4 !== 1'b0 || busy4 !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rc_abandoned: got activity=%b expected 0", seen);
        end
        req_a4 = {8'd0, 8'd0, 8'd17, 8'd0};
        req_b4 = {8'd0, 8'd0, 8'd15, 8'd0};
        req_valid4 = 4'b1010;
        #1;
        checks++;
        if (req_ready4 !== 4'b0010) begin
            errors++; $display("FAIL rc_ptr_reset: got %b expected 0010", req_ready4);
        end
        tick();
        req_valid4 = 4'b0000;
        n = 0;
        do begin
            tick(); n++;
        end while (res_valid4 !== 1'b1 && n < 10);
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL rc_latency: got %0d edges expected 4", n);
        end
        checks++;
        if (res_product4 !== 16'd255 || res_id4 !== 2'd1) begin
            errors++; $display("FAIL rc_result: got prod=%0d id=%0d expected 255 1", res_product4, res_id4);
        end
    endtask

    initial begin
        reset4 = 1'b1; req_valid4 = 4'b0000; req_a4 = '0; req_b4 = '0; res_ready4 = 1'b1;
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_backpressure();
        test_reset_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
